// File: rtl/call_stack_ctrl.sv
// Call/return sequencer that saves 16-bit return addresses on an external 8-bit stack.
// Build option CALLSTK_ERR_TRAP_EN: errors become sticky and redirect pc_out to TRAP_VECTOR.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for call/ret, flags request errors
// S_PUSH_LO | pushing ret_addr[7:0]
// S_PUSH_HI | pushing ret_addr[15:8], then jump to target
// S_POP_HI  | popping high byte (returns next cycle)
// S_POP_LO  | popping low byte, capturing high byte
// S_WAIT_LO | low byte on stk_rdata, load pc_out
module call_stack_ctrl #(
   parameter int          STACK_DEPTH = 32,
   parameter logic [15:0] TRAP_VECTOR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        call,
   input  logic        ret,
   input  logic [15:0] ret_addr,
   input  logic [15:0] call_target,
   output logic [15:0] pc_out,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        stk_push,
   output logic        stk_pop,
   output logic [7:0]  stk_wdata,
   input  logic [7:0]  stk_rdata,
   input  logic        stk_empty,
   input  logic        stk_full
);

`ifdef CALLSTK_ERR_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam int            CW           = $clog2(STACK_DEPTH + 1);
   localparam logic [CW-1:0] CNT_TWO      = CW'(2);
   localparam logic [CW-1:0] CNT_MAX_CALL = CW'(STACK_DEPTH - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_PUSH_LO, S_PUSH_HI, S_POP_HI, S_POP_LO, S_WAIT_LO
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   ra_q, ra_d;
   logic [15:0]   tgt_q, tgt_d;
   logic [15:0]   pc_q, pc_d;
   logic [7:0]    hi_q, hi_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          lock;
   logic          call_ok, ret_ok;
   logic [7:0]    wdata_c;

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      tgt_d   = tgt_q;
      pc_d    = pc_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = TRAP_EN ? err_q : 1'b0;
      // A trapped controller stays halted until reset, so done can never join a sticky err.
      lock    = TRAP_EN && err_q;
      call_ok = call && !ret && (cnt_q <= CNT_MAX_CALL) && !stk_full;
      ret_ok  = ret && !call && (cnt_q >= CNT_TWO) && !stk_empty;
      case (state_q)
         S_IDLE: begin
            if (!lock) begin
               if (call_ok) begin
                  ra_d    = ret_addr;
                  tgt_d   = call_target;
                  state_d = S_PUSH_LO;
               end else if (ret_ok) begin
                  state_d = S_POP_HI;
               end else if (call || ret) begin
                  err_d = 1'b1;
                  if (TRAP_EN) pc_d = TRAP_VECTOR;
               end
            end
         end
         S_PUSH_LO: state_d = S_PUSH_HI;
         S_PUSH_HI: begin
            pc_d    = tgt_q;
            cnt_d   = cnt_q + CNT_TWO;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_POP_HI: state_d = S_POP_LO;
         S_POP_LO: begin
            hi_d    = stk_rdata;
            state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            pc_d    = {hi_q, stk_rdata};
            cnt_d   = cnt_q - CNT_TWO;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         tgt_q   <= '0;
         pc_q    <= '0;
         hi_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         tgt_q   <= tgt_d;
         pc_q    <= pc_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Outputs are forced quiet during the reset cycle itself so an aborted sequence strobes no more.
   always_comb begin
      wdata_c = 8'h00;
      if (!rst) begin
         if (state_q == S_PUSH_LO)      wdata_c = ra_q[7:0];
         else if (state_q == S_PUSH_HI) wdata_c = ra_q[15:8];
      end
   end

   assign stk_wdata = wdata_c;
   assign stk_push  = !rst && ((state_q == S_PUSH_LO) || (state_q == S_PUSH_HI));
   assign stk_pop   = !rst && ((state_q == S_POP_HI) || (state_q == S_POP_LO));
   assign busy      = !rst && (state_q != S_IDLE);
   assign pc_out    = rst ? 16'h0000 : pc_q;
   assign done      = !rst && done_q;
   assign err       = !rst && err_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Bench for call_stack_ctrl: behavioural 8-bit stack, return-address-stack model with a
// per-cycle expected-output timeline, and directed scenarios with literal checks.
module tb_call_stack_ctrl;

   localparam int          DEPTH = 32;
   localparam logic [15:0] TRAP  = 16'hFFF0;
`ifdef CALLSTK_ERR_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk, rst, call, ret;
   logic [15:0] ret_addr, call_target, pc_out;
   logic        busy, done, err, stk_push, stk_pop, stk_empty, stk_full;
   logic [7:0]  stk_wdata, stk_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   call_stack_ctrl #(.STACK_DEPTH(DEPTH), .TRAP_VECTOR(TRAP)) dut (
      .clk(clk), .rst(rst), .call(call), .ret(ret), .ret_addr(ret_addr),
      .call_target(call_target), .pc_out(pc_out), .busy(busy), .done(done), .err(err),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
      .stk_rdata(stk_rdata), .stk_empty(stk_empty), .stk_full(stk_full));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Stack: popped byte visible the cycle after the pop, flags registered.
   logic [7:0] smem [DEPTH];
   int         sp;
   logic [7:0] srd;
   logic       sempty, sfull;
   assign stk_rdata = srd;
   assign stk_empty = sempty;
   assign stk_full  = sfull;

   always @(posedge clk) begin
      if (rst) begin
         sp = 0;
         srd    <= 8'h00;
         sempty <= 1'b1;
         sfull  <= 1'b0;
      end else begin
         if (stk_push && sp < DEPTH) begin
            smem[sp] = stk_wdata;
            sp = sp + 1;
         end else if (stk_pop && sp > 0) begin
            sp = sp - 1;
            srd <= smem[sp];
         end
         sempty <= (sp == 0);
         sfull  <= (sp == DEPTH);
      end
   end

   // Model: a stack of 16-bit return addresses plus a timeline of expected output cycles.
   typedef struct {
      logic        push, pop;
      logic [7:0]  wd;
      logic        busy, done, err;
      logic [15:0] pc;
      int          cnt;
   } exp_t;

   exp_t        tl[$];
   exp_t        cur;
   logic [15:0] ras[$];
   int          cnt_m;
   logic [15:0] pc_m;
   logic        sticky;

   function automatic exp_t idle_e();
      exp_t e;
      e.push = 0; e.pop = 0; e.wd = 8'h00; e.busy = 0; e.done = 0;
      e.err = sticky; e.pc = pc_m; e.cnt = cnt_m;
      return e;
   endfunction

   task automatic model_step();
      logic prev_busy;
      logic [15:0] ra;
      exp_t e;
      prev_busy = cur.busy;
      if (rst) begin
         tl.delete(); ras.delete();
         cnt_m = 0; pc_m = 16'h0000; sticky = 1'b0;
         cur = idle_e();
      end else if (tl.size() > 0) begin
         cur = tl.pop_front();
      end else begin
         cur = idle_e();
         if (!prev_busy && !sticky && (call || ret)) begin
            if (call && !ret && cnt_m <= DEPTH - 2 && !stk_full) begin
               e = idle_e(); e.busy = 1; e.push = 1; e.wd = ret_addr[7:0];
               cur = e;
               e.wd = ret_addr[15:8];
               tl.push_back(e);
               ras.push_back(ret_addr);
               cnt_m = cnt_m + 2; pc_m = call_target;
               e = idle_e(); e.done = 1;
               tl.push_back(e);
            end else if (ret && !call && cnt_m >= 2 && !stk_empty) begin
               e = idle_e(); e.busy = 1; e.pop = 1;
               cur = e;
               tl.push_back(e);
               e.pop = 0;
               tl.push_back(e);
               ra = ras.pop_back();
               cnt_m = cnt_m - 2; pc_m = ra;
               e = idle_e(); e.done = 1;
               tl.push_back(e);
            end else begin
               if (TRAP_EN) begin
                  sticky = 1'b1; pc_m = TRAP;
               end
               cur = idle_e(); cur.err = 1;
            end
         end
      end
   endtask

   initial begin
      sticky = 0; cnt_m = 0; pc_m = 0;
      cur = idle_e();
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("busy", {31'b0, busy}, {31'b0, cur.busy});
         chk("done", {31'b0, done}, {31'b0, cur.done});
         chk("err", {31'b0, err}, {31'b0, cur.err});
         chk("stk_push", {31'b0, stk_push}, {31'b0, cur.push});
         chk("stk_pop", {31'b0, stk_pop}, {31'b0, cur.pop});
         chk("stk_wdata", {24'b0, stk_wdata}, {24'b0, cur.wd});
         chk("pc_out", {16'b0, pc_out}, {16'b0, cur.pc});
         chk("byte_cnt", 32'(dut.cnt_q), cur.cnt);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic do_call(input logic [15:0] a, input logic [15:0] t);
      @(negedge clk);
      call = 1'b1; ret_addr = a; call_target = t;
      @(negedge clk);
      call = 1'b0;
   endtask

   task automatic do_ret();
      @(negedge clk) ret = 1'b1;
      @(negedge clk) ret = 1'b0;
   endtask

   initial begin
      rst = 1'b1; call = 1'b0; ret = 1'b0; ret_addr = 16'h0; call_target = 16'h0;
      cyc(3);
      chk("rst_pc", {16'b0, pc_out}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      rst = 1'b0;
      cyc(2);

      // Basic call then ret.
      do_call(16'h1234, 16'h0400);
      chk("call_c1_push", {31'b0, stk_push}, 32'h1);
      chk("call_c1_wd", {24'b0, stk_wdata}, 32'h34);
      chk("call_c1_busy", {31'b0, busy}, 32'h1);
      cyc(1);
      chk("call_c2_wd", {24'b0, stk_wdata}, 32'h12);
      chk("call_c2_busy", {31'b0, busy}, 32'h1);
      cyc(1);
      chk("call_c3_done", {31'b0, done}, 32'h1);
      chk("call_c3_pc", {16'b0, pc_out}, 32'h0400);
      chk("call_c3_busy", {31'b0, busy}, 32'h0);
      chk("stack_lo", {24'b0, smem[0]}, 32'h34);
      chk("stack_hi", {24'b0, smem[1]}, 32'h12);
      do_ret();
      chk("ret_c1_pop", {31'b0, stk_pop}, 32'h1);
      cyc(1);
      chk("ret_c2_pop", {31'b0, stk_pop}, 32'h1);
      cyc(1);
      chk("ret_c3_pop", {31'b0, stk_pop}, 32'h0);
      chk("ret_c3_done", {31'b0, done}, 32'h0);
      cyc(1);
      chk("ret_c4_done", {31'b0, done}, 32'h1);
      chk("ret_c4_pc", {16'b0, pc_out}, 32'h1234);
      cyc(2);

      // Nested calls and returns in LIFO order.
      do_reset();
      do_call(16'hA001, 16'h0010); cyc(2);
      do_call(16'hB002, 16'h0020); cyc(2);
      do_call(16'hC003, 16'h0030); cyc(2);
      do_ret(); cyc(3);
      chk("nest_ret1", {16'b0, pc_out}, 32'hC003);
      do_ret(); cyc(3);
      chk("nest_ret2", {16'b0, pc_out}, 32'hB002);
      do_ret(); cyc(3);
      chk("nest_ret3", {16'b0, pc_out}, 32'hA001);
      chk("nest_cnt", 32'(dut.cnt_q), 32'd0);
      cyc(2);

      // Overflow after 16 calls.
      do_reset();
      for (int k = 0; k < 16; k++) begin
         do_call(16'(k), 16'h1000 + 16'(k));
         cyc(2);
      end
      chk("full_cnt", 32'(dut.cnt_q), 32'd32);
      do_call(16'h00EE, 16'h2000);
      chk("ovf_push", {31'b0, stk_push}, 32'h0);
      chk("ovf_err", {31'b0, err}, 32'h1);
      chk("ovf_cnt", 32'(dut.cnt_q), 32'd32);
      chk("ovf_pc", {16'b0, pc_out}, TRAP_EN ? 32'(TRAP) : 32'h100F);
      cyc(1);
      chk("ovf_err_next", {31'b0, err}, TRAP_EN ? 32'h1 : 32'h0);
      cyc(2);

      // Underflow right after reset.
      do_reset();
      do_ret();
      chk("unf_pop", {31'b0, stk_pop}, 32'h0);
      chk("unf_err", {31'b0, err}, 32'h1);
      chk("unf_pc", {16'b0, pc_out}, TRAP_EN ? 32'(TRAP) : 32'h0);
      cyc(1);
      chk("unf_err_next", {31'b0, err}, TRAP_EN ? 32'h1 : 32'h0);
      cyc(2);

      // Call pulse while busy is ignored; then call+ret together.
      do_reset();
      do_call(16'hA5A5, 16'h0100);
      cyc(1);
      call = 1'b1; ret_addr = 16'h5A5A; call_target = 16'h0200;
      cyc(1);
      call = 1'b0;
      chk("busy_ign_pc", {16'b0, pc_out}, 32'h0100);
      chk("busy_ign_err", {31'b0, err}, 32'h0);
      cyc(3);
      chk("busy_ign_cnt", 32'(dut.cnt_q), 32'd2);
      @(negedge clk);
      call = 1'b1; ret = 1'b1;
      @(negedge clk);
      call = 1'b0; ret = 1'b0;
      chk("both_err", {31'b0, err}, 32'h1);
      chk("both_push", {31'b0, stk_push}, 32'h0);
      chk("both_pop", {31'b0, stk_pop}, 32'h0);
      chk("both_pc", {16'b0, pc_out}, TRAP_EN ? 32'(TRAP) : 32'h0100);
      cyc(2);

      // Reset during POP_LO.
      do_reset();
      do_call(16'h4321, 16'h0800);
      cyc(2);
      do_ret();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("rstmid_pop", {31'b0, stk_pop}, 32'h0);
      chk("rstmid_busy", {31'b0, busy}, 32'h0);
      chk("rstmid_pc", {16'b0, pc_out}, 32'h0);
      chk("rstmid_cnt", 32'(dut.cnt_q), 32'd0);
      cyc(1);
      chk("rstmid_pop2", {31'b0, stk_pop}, 32'h0);
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
